// File: rtl/decoder_n_hs_if.sv
// Valid/ready bus for the registered N-to-2^N decoder.
// Codes flow from master to slave, results flow back.
interface decoder_n_hs_if #(
  parameter int N = 2
);
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     in_code;
  logic             out_valid;
  logic             out_ready;
  logic [2**N-1:0]  out_dec;
  logic [N-1:0]     out_code;

  modport master (
    output in_valid,
    output in_code,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_dec,
    input  out_code
  );

  modport slave (
    input  in_valid,
    input  in_code,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_dec,
    output out_code
  );
endinterface

// File: rtl/decoder_n_hs.sv
// Registered N-to-2^N one-hot decoder with valid/ready
// handshakes and an internal sweep counter for chasers.
module decoder_n_hs #(
  parameter int N          = 2,
  parameter int ACTIVE_LOW = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sweep,
  decoder_n_hs_if.slave    bus
);
  localparam int W = 2**N;
  localparam logic [W-1:0] INACT =
    (ACTIVE_LOW != 0) ? {W{1'b1}} : {W{1'b0}};
  localparam logic [W-1:0] ONE =
    {{(W-1){1'b0}}, 1'b1};

  logic         valid_q;
  logic [W-1:0] dec_q;
  logic [N-1:0] code_q;
  logic [N-1:0] cnt;
  logic         sweep_q;

  logic         load_ok;
  logic         rise;
  logic         load;
  logic [N-1:0] cnt_eff;
  logic [N-1:0] ld_code;
  logic [W-1:0] ld_dec;

  always_comb begin
    load_ok = ~valid_q | bus.out_ready;
    rise    = sweep & ~sweep_q;
    // a fresh sweep starts at code 0 on the same edge
    cnt_eff = rise ? '0 : cnt;
    load    = sweep ? load_ok
                    : (bus.in_valid & load_ok);
    ld_code = sweep ? cnt_eff : bus.in_code;
    ld_dec  = (ONE << ld_code) ^ INACT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= INACT;
      code_q  <= '0;
      cnt     <= '0;
      sweep_q <= 1'b0;
    end else begin
      sweep_q <= sweep;
      if (sweep)
        cnt <= load ? cnt_eff + 1'b1 : cnt_eff;
      if (load) begin
        valid_q <= 1'b1;
        dec_q   <= ld_dec;
        code_q  <= ld_code;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
        dec_q   <= INACT;
      end
    end
  end

  assign bus.in_ready  = load_ok & ~sweep;
  assign bus.out_valid = valid_q;
  assign bus.out_dec   = dec_q;
  assign bus.out_code  = code_q;
endmodule
